// File: rtl/regfile.sv
// Two-read, one-write integer register file for the ID/WB stages with
// same-cycle WB-to-ID bypass and a committed-write trace (count, last addr/data).
module regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re1,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic            re2,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    output logic [31:0]     wr_cnt,
    output logic [AW-1:0]   last_waddr,
    output logic [XLEN-1:0] last_wdata
);

    localparam int unsigned NREG  = 2 ** AW;
    localparam int unsigned CNT_W = 32;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] wr_cnt_q,     wr_cnt_d;
    logic [AW-1:0]    last_waddr_q, last_waddr_d;
    logic [XLEN-1:0]  last_wdata_q, last_wdata_d;
    logic             commit_c;

    // Writes to x0 are bubbles and leave every piece of state untouched.
    assign commit_c = rst && we && (waddr != '0);

    // Read port: zero when disabled, x0 or in reset; bypass beats storage.
    function automatic logic [XLEN-1:0] read_port(
        input logic            rst_v,
        input logic            re_v,
        input logic [AW-1:0]   ra_v,
        input logic            we_v,
        input logic [AW-1:0]   wa_v,
        input logic [XLEN-1:0] wd_v,
        input logic [XLEN-1:0] stored_v
    );
        logic [XLEN-1:0] res;
        res = '0;
        if (rst_v && re_v && (ra_v != '0)) begin
            if (we_v && (wa_v == ra_v)) begin
                res = wd_v;
            end else begin
                res = stored_v;
            end
        end
        return res;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
        rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
    end

    // Next-state for storage and write trace.
    always_comb begin
        regs_d       = regs_q;
        wr_cnt_d     = wr_cnt_q;
        last_waddr_d = last_waddr_q;
        last_wdata_d = last_wdata_q;
        if (commit_c) begin
            regs_d[waddr] = wdata;
            wr_cnt_d      = wr_cnt_q + CNT_W'(1);
            last_waddr_d  = waddr;
            last_wdata_d  = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q     <= '0;
            last_waddr_q <= '0;
            last_wdata_q <= '0;
        end else begin
            regs_q       <= regs_d;
            wr_cnt_q     <= wr_cnt_d;
            last_waddr_q <= last_waddr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

    assign wr_cnt     = wr_cnt_q;
    assign last_waddr = last_waddr_q;
    assign last_wdata = last_wdata_q;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            re1;
    logic [AW-1:0]   raddr1;
    logic [XLEN-1:0] rdata1;
    logic            re2;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata2;
    logic [31:0]     wr_cnt;
    logic [AW-1:0]   last_waddr;
    logic [XLEN-1:0] last_wdata;

    regfile #(.XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wr_cnt     (wr_cnt),
        .last_waddr (last_waddr),
        .last_wdata (last_wdata)
    );

    always #5 clk = ~clk;

    typedef enum int { S_RD1, S_RD2, S_CNT, S_LWA, S_LWD } sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic expect_v(input string name, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [31:0] wd, input logic e1, input logic [AW-1:0] a1,
                         input logic e2, input logic [AW-1:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    endtask

    // Monitor: everything queued during a cycle is checked at its falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                S_RD1:   act = rdata1;
                S_RD2:   act = rdata2;
                S_CNT:   act = wr_cnt;
                S_LWA:   act = 32'(last_waddr);
                default: act = last_wdata;
            endcase
            ntests++;
            if (act !== e.exp) begin
                nfail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        step();
        step();
        expect_v("rst_rd1",  S_RD1, 32'h0);
        expect_v("rst_cnt",  S_CNT, 32'h0);
        expect_v("rst_lwa",  S_LWA, 32'h0);
        expect_v("rst_lwd",  S_LWD, 32'h0);

        // First edge after reset release commits.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b0, 5'd0);
        expect_v("re1_off", S_RD1, 32'h0);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        expect_v("x5_read", S_RD1, 32'hDEADBEEF);
        expect_v("cnt_1",   S_CNT, 32'd1);
        expect_v("lwa_5",   S_LWA, 32'd5);
        expect_v("lwd_5",   S_LWD, 32'hDEADBEEF);

        // Dual bypass on same address.
        step();
        drive(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        expect_v("byp_rd1", S_RD1, 32'h12345678);
        expect_v("byp_rd2", S_RD2, 32'h12345678);
        expect_v("byp_cnt", S_CNT, 32'd1);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
        expect_v("x7_read", S_RD1, 32'h12345678);
        expect_v("cnt_2",   S_CNT, 32'd2);
        expect_v("lwa_7",   S_LWA, 32'd7);

        // Bubble write to x0.
        step();
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        expect_v("x0_byp1", S_RD1, 32'h0);
        expect_v("x0_byp2", S_RD2, 32'h0);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        expect_v("x0_read", S_RD1, 32'h0);
        expect_v("nop_cnt", S_CNT, 32'd2);
        expect_v("nop_lwa", S_LWA, 32'd7);
        expect_v("nop_lwd", S_LWD, 32'h12345678);

        // Read-enable gating on port 2; other-address read during write.
        step();
        drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b1, 5'd5);
        expect_v("nobyp_rd2", S_RD2, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
        expect_v("re2_off", S_RD2, 32'h0);
        expect_v("x3_rd1",  S_RD1, 32'hA5A5A5A5);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3);
        expect_v("x3_rd2",  S_RD2, 32'hA5A5A5A5);

        // Bypass takes priority over the stored value.
        step();
        drive(1'b1, 1'b1, 5'd3, 32'h0BADF00D, 1'b1, 5'd3, 1'b1, 5'd5);
        expect_v("byp_over", S_RD1, 32'h0BADF00D);
        expect_v("byp_oth",  S_RD2, 32'hDEADBEEF);
        expect_v("byp_cnt3", S_CNT, 32'd3);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        expect_v("x3_new", S_RD1, 32'h0BADF00D);
        expect_v("cnt_4",  S_CNT, 32'd4);
        expect_v("lwa_3",  S_LWA, 32'd3);

        // Reset wins over a concurrent write; state clears only at the edge.
        step();
        drive(1'b0, 1'b1, 5'd9, 32'h1, 1'b1, 5'd3, 1'b0, 5'd0);
        expect_v("rst_rd0",  S_RD1, 32'h0);
        expect_v("rst_hold", S_CNT, 32'd4);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd3);
        expect_v("x9_clr",  S_RD1, 32'h0);
        expect_v("x3_clr",  S_RD2, 32'h0);
        expect_v("cnt_clr", S_CNT, 32'h0);
        expect_v("lwa_clr", S_LWA, 32'h0);
        expect_v("lwd_clr", S_LWD, 32'h0);

        // Counter wrap: preload near the top, then two committed writes.
        step();
        force dut.wr_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.wr_cnt_q;
        drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_v("cnt_max", S_CNT, 32'hFFFFFFFF);
        expect_v("lwa_4",   S_LWA, 32'd4);
        step();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd6);
        expect_v("cnt_wrap", S_CNT, 32'h0);
        expect_v("lwa_6",    S_LWA, 32'd6);
        expect_v("lwd_66",   S_LWD, 32'h66);
        expect_v("x4_read",  S_RD1, 32'h44);
        expect_v("x6_read",  S_RD2, 32'h66);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
